// File: rtl/gate_truth_checker.sv
// Sequential exhaustive tester for a 2-input gate: walks {a,b} through 00..11, samples dut_out
// after SETTLE cycles per vector, and reports per-vector results plus a pass/fail verdict.
module gate_truth_checker #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [3:0]  EXPECTED = 4'b0111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dut_out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] sampled,
    output logic [3:0] fail_mask
);

    if (SETTLE < 1) begin : g_bad_settle
        $error("gate_truth_checker: SETTLE must be >= 1");
    end

    localparam int unsigned TW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e          r_state,   w_state_next;
    logic [1:0]      r_idx,     w_idx_next;
    logic [TW-1:0]   r_timer,   w_timer_next;
    logic [3:0]      r_sampled, w_sampled_next;
    logic [3:0]      r_fail,    w_fail_next;
    logic            r_pass,    w_pass_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_idx     <= 2'b00;
            r_timer   <= '0;
            r_sampled <= 4'b0000;
            r_fail    <= 4'b0000;
            r_pass    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_timer   <= w_timer_next;
            r_sampled <= w_sampled_next;
            r_fail    <= w_fail_next;
            r_pass    <= w_pass_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_timer_next   = r_timer;
        w_sampled_next = r_sampled;
        w_fail_next    = r_fail;
        w_pass_next    = r_pass;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_idx_next     = 2'b00;
                    w_timer_next   = TW'(SETTLE);
                    w_sampled_next = 4'b0000;
                    w_fail_next    = 4'b0000;
                    w_pass_next    = 1'b0;
                    w_state_next   = StWait;
                end
            end
            StWait: begin
                if (r_timer != TW'(1)) begin
                    w_timer_next = r_timer - TW'(1);
                end else begin
                    w_sampled_next[r_idx] = dut_out;
                    w_fail_next[r_idx]    = dut_out ^ EXPECTED[r_idx];
                    if (r_idx == 2'd3) begin
                        // Verdict includes the vector captured on this same edge.
                        w_pass_next  = ~|w_fail_next;
                        w_state_next = StDone;
                    end else begin
                        w_idx_next   = r_idx + 2'd1;
                        w_timer_next = TW'(SETTLE);
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // The vector index directly drives the gate inputs, so a/b hold 11 after a run.
    assign a         = r_idx[1];
    assign b         = r_idx[0];
    assign busy      = (r_state != StIdle);
    assign done      = (r_state == StDone);
    assign pass      = r_pass;
    assign sampled   = r_sampled;
    assign fail_mask = r_fail;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: stimulus pushes expected results per accepted run,
// monitors pop and compare on each done pulse.
module tb_gate_truth_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start2;
    logic       dut_out1, dut_out2;
    logic       a1, b1, busy1, done1, pass1;
    logic       a2, b2, busy2, done2, pass2;
    logic [3:0] sampled1, fail_mask1, sampled2, fail_mask2;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         mode = 0;          // 0 NAND, 1 AND, 2 stuck-at-1
    int         last_done2 = -1;
    int         n_done2 = 0;

    logic [8:0] q1[$];             // {sampled, fail_mask, pass}
    logic [8:0] q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        case (mode)
            0:       dut_out1 = ~(a1 & b1);
            1:       dut_out1 = a1 & b1;
            default: dut_out1 = 1'b1;
        endcase
    end
    assign dut_out2 = ~(a2 & b2);

    gate_truth_checker #(.SETTLE(2), .EXPECTED(4'b0111)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .dut_out(dut_out1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .sampled(sampled1), .fail_mask(fail_mask1)
    );

    gate_truth_checker #(.SETTLE(1), .EXPECTED(4'b0111)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .dut_out(dut_out2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .sampled(sampled2), .fail_mask(fail_mask2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the SETTLE=2 instance.
    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = q1.pop_front();
                chk("dut1_sampled", {28'd0, sampled1}, {28'd0, e[8:5]});
                chk("dut1_fail_mask", {28'd0, fail_mask1}, {28'd0, e[4:1]});
                chk("dut1_pass", {31'd0, pass1}, {31'd0, e[0]});
            end
        end
    end

    // Monitor for the SETTLE=1 instance, also checking the done-to-done period.
    always @(negedge clk) begin
        if (done2) begin
            n_done2++;
            if (last_done2 >= 0) chk("dut2_done_period", cyc - last_done2, 32'd6);
            last_done2 = cyc;
            if (q2.size() == 0) begin
                chk("dut2_unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = q2.pop_front();
                chk("dut2_sampled", {28'd0, sampled2}, {28'd0, e[8:5]});
                chk("dut2_fail_mask", {28'd0, fail_mask2}, {28'd0, e[4:1]});
                chk("dut2_pass", {31'd0, pass2}, {31'd0, e[0]});
            end
        end
    end

    // One SETTLE=2 run on dut1; optionally pokes start at E0+3 and in the DONE cycle.
    task automatic run1(input int m, input logic [8:0] exp, input bit extra);
        mode   = m;
        start1 = 1'b1;
        q1.push_back(exp);
        tick();                              // E0
        start1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("ab_sequence", {30'd0, a1, b1}, k / 2);
            chk("busy_in_wait", {31'd0, busy1}, 32'd1);
            if (extra && k == 2) start1 = 1'b1;
            if (extra && k == 3) start1 = 1'b0;
            tick();
        end
        chk("done_cycle_done", {31'd0, done1}, 32'd1);
        chk("done_cycle_busy", {31'd0, busy1}, 32'd1);
        if (extra) start1 = 1'b1;
        tick();                              // DONE exit edge
        start1 = 1'b0;
        chk("after_done_busy", {31'd0, busy1}, 32'd0);
        chk("after_done_done", {31'd0, done1}, 32'd0);
        chk("after_done_ab", {30'd0, a1, b1}, 32'd3);
        tick();
        tick();
        chk("idle_holds_busy", {31'd0, busy1}, 32'd0);
        chk("idle_holds_pass", {31'd0, pass1}, {31'd0, exp[0]});
    endtask

    initial begin
        reset  = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_pass", {31'd0, pass1}, 32'd0);
        chk("rst_ab", {30'd0, a1, b1}, 32'd0);
        chk("rst_sampled", {28'd0, sampled1}, 32'd0);
        chk("rst_fail_mask", {28'd0, fail_mask1}, 32'd0);
        chk("rst_busy2", {31'd0, busy2}, 32'd0);

        run1(0, {4'b0111, 4'b0000, 1'b1}, 1'b0);   // NAND
        run1(1, {4'b1000, 4'b1111, 1'b0}, 1'b0);   // AND
        run1(2, {4'b1111, 4'b1000, 1'b0}, 1'b0);   // stuck-at-1
        run1(0, {4'b0111, 4'b0000, 1'b1}, 1'b1);   // ignored extra starts

        // Abort a run with reset at E0+3.
        mode   = 0;
        start1 = 1'b1;
        tick();                                    // E0
        start1 = 1'b0;
        tick();
        tick();
        chk("mid_run_sampled0", {31'd0, sampled1[0]}, 32'd1);
        reset = 1'b1;
        tick();                                    // E0+3
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_done", {31'd0, done1}, 32'd0);
        chk("abort_ab", {30'd0, a1, b1}, 32'd0);
        chk("abort_sampled", {28'd0, sampled1}, 32'd0);
        chk("abort_fail_mask", {28'd0, fail_mask1}, 32'd0);
        for (int k = 0; k < 12; k++) tick();       // monitor flags any stray done
        run1(0, {4'b0111, 4'b0000, 1'b1}, 1'b0);

        // SETTLE=1, start held for 18 edges: runs accepted at k, k+6, k+12.
        for (int r = 0; r < 3; r++) q2.push_back({4'b0111, 4'b0000, 1'b1});
        start2 = 1'b1;
        for (int k = 0; k < 18; k++) tick();
        start2 = 1'b0;
        for (int k = 0; k < 40 && q2.size() != 0; k++) tick();
        tick();
        tick();
        chk("dut2_done_count", n_done2, 32'd3);
        chk("dut2_queue_empty", q2.size(), 32'd0);
        chk("dut1_queue_empty", q1.size(), 32'd0);
        chk("dut2_idle_after", {31'd0, busy2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Sequential exhaustive tester for any 2-input combinational gate in the basics library, for example the nand cells.
- It drives the gate inputs a/b through all four combinations, waits a settle time, samples the gate output, and compares it against an expected truth table.
- It reports a per-vector mismatch mask and a pass/fail verdict with a start/done handshake.
- It lets synthesizable self-test logic check a gate instance in place of a hand-written initial-block stimulus.

Parameters:
- SETTLE, 2: cycles each vector is held before dut_out is sampled. Legal range is >= 1; 0 is illegal and the implementation must elaborate-time error.
- EXPECTED, 4'b0111: expected dut_out per vector. Bit i is the expected value for {a,b} = i. The default is the NAND truth table.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a run; honoured only in IDLE
- dut_out  in  1  output of the gate under test
- a  out  1  gate input a (MSB of vector index)
- b  out  1  gate input b (LSB of vector index)
- busy  out  1  high while a run is in progress (WAIT and DONE states)
- done  out  1  one-cycle pulse when a run completes
- pass  out  1  1 when fail_mask == 0; valid from done, held until next accepted start
- sampled  out  4  captured dut_out per vector index
- fail_mask  out  4  bit i = sampled[i] XOR EXPECTED[i]

Behaviour:
- Reset (synchronous): state=IDLE. a, b, busy, done, pass, sampled, fail_mask, the internal idx (2b) and the timer are all 0. Reset wins over every other event, including mid-run; no done pulse is produced for an aborted run.
- IDLE:
  - start==0: outputs hold their last run's results.
  - start==1 at an edge: idx<=0, {a,b}<=2'b00, timer<=SETTLE, sampled<=0, fail_mask<=0, pass<=0, state<=WAIT.
- WAIT, at each edge:
  - If timer != 1: timer<=timer-1.
  - If timer == 1: sampled[idx]<=dut_out and fail_mask[idx]<=dut_out^EXPECTED[idx]. Then:
    - idx==3: state<=DONE, pass<=(final fail_mask==0), with the idx-3 result included.
    - otherwise: idx<=idx+1, {a,b}<=idx+1, timer<=SETTLE.
- Sample timing: dut_out is sampled on edge E0+SETTLE*(idx+1), where E0 is the edge that accepted start. dut_out must therefore be stable SETTLE cycles after the a/b change.
- DONE: lasts exactly 1 cycle. done=1, busy=1. Next edge: state<=IDLE, done<=0. a/b hold 2'b11 until the next start.
- busy=1 exactly in WAIT and DONE. Run length from E0 to the DONE exit edge is 4*SETTLE+1 cycles.
- start while busy (WAIT or DONE) is ignored; there is no queueing.
- start held high continuously: a new run is accepted on the first edge in IDLE. The period between done pulses is 4*SETTLE+2 cycles.
- sampled and fail_mask update incrementally during a run. They are final when done=1 and are stable until the next accepted start.

Test Plan:
1. SETTLE=2, dut_out = ~(a&b) combinational, 1-cycle start pulse -> samples at E0+2/4/6/8; done high the cycle after E0+8; sampled=4'b0111, fail_mask=4'b0000, pass=1.
2. Same, dut_out = a&b -> sampled=4'b1000, fail_mask=4'b1111, pass=0, single done pulse.
3. dut_out stuck at 1 -> sampled=4'b1111, fail_mask=4'b1000, pass=0; a/b sequence observed as 00,01,10,11, each held 2 cycles.
4. NAND dut, extra start pulses at E0+3 and during the DONE cycle -> ignored; exactly one done pulse; busy high for 9 cycles; pass=1.
5. NAND dut, reset asserted for one cycle at E0+3 -> next edge shows state IDLE, busy=0, a=b=0, sampled=0, no done pulse. A fresh start then gives pass=1.
6. SETTLE=1, NAND dut, start held high -> done pulses every 6 cycles; each run gives sampled=4'b0111, pass=1.
